// File: rtl/video_mixer_pipe_if.sv
// Video mixer pixel bus: pixel strobe, mode controls, colour/sync in, VGA out.
// master drives ce_pix, modes, R/G/B, HSync/VSync; slave drives VGA_*.
interface video_mixer_pipe_if #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 6
);
  logic                ce_pix;
  logic [1:0]          scanlines;
  logic                csync_en;
  logic                ypbpr;
  logic                ypbpr_full;
  logic [IN_BITS-1:0]  R;
  logic [IN_BITS-1:0]  G;
  logic [IN_BITS-1:0]  B;
  logic                HSync;
  logic                VSync;
  logic [OUT_BITS-1:0] VGA_R;
  logic [OUT_BITS-1:0] VGA_G;
  logic [OUT_BITS-1:0] VGA_B;
  logic                VGA_HS;
  logic                VGA_VS;

  modport master (
    output ce_pix, scanlines, csync_en, ypbpr, ypbpr_full,
    output R, G, B, HSync, VSync,
    input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS
  );

  modport slave (
    input  ce_pix, scanlines, csync_en, ypbpr, ypbpr_full,
    input  R, G, B, HSync, VSync,
    output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS
  );
endinterface

// File: rtl/video_mixer_pipe.sv
// 4-stage video mixer: scanline attenuation, RGB->YPbPr, dither/quantise, sync.
// Ports: clk_sys, reset_n (async low), vid (slave modport: inputs + VGA_* out).
module video_mixer_pipe #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 6,
  parameter int DITHER   = 1
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  video_mixer_pipe_if.slave vid
);

  localparam int W    = IN_BITS;
  localparam int A    = IN_BITS + 10;
  localparam int DIFF = IN_BITS - OUT_BITS;
  localparam bit DO_DITH = (DITHER != 0) && (DIFF >= 2);
  localparam int DSH  = DO_DITH ? DIFF - 2 : 0;
  localparam int K    = 1 << (IN_BITS - 8);

  typedef logic signed [A-1:0] acc_t;

  localparam acc_t C18  = A'(18);
  localparam acc_t C25  = A'(25);
  localparam acc_t C38  = A'(38);
  localparam acc_t C66  = A'(66);
  localparam acc_t C74  = A'(74);
  localparam acc_t C94  = A'(94);
  localparam acc_t C112 = A'(112);
  localparam acc_t C129 = A'(129);
  localparam acc_t C255 = A'(255);
  localparam acc_t C291 = A'(291);
  localparam acc_t C298 = A'(298);
  localparam acc_t L16  = A'(16 * K);
  localparam acc_t L128 = A'(128 * K);
  localparam acc_t L235 = A'(235 * K);
  localparam acc_t L240 = A'(240 * K);
  localparam acc_t CMAX = A'((1 << W) - 1);
  localparam logic [W-1:0] MAXV = '1;

  typedef struct packed {
    logic hs;
    logic vs;
    logic lp;
    logic pp;
    logic cs;
    logic yp;
    logic yf;
  } ctl_t;

  function automatic logic [W-1:0] atten(
    input logic [W-1:0] x,
    input logic [1:0]   m,
    input logic         en
  );
    logic [W-1:0] y;
    y = x;
    if (en) begin
      case (m)
        2'd1:    y = (x >> 1) + (x >> 2);
        2'd2:    y = x >> 1;
        2'd3:    y = x >> 2;
        default: y = x;
      endcase
    end
    return y;
  endfunction

  // Signed divide by 256 rounding toward zero.
  function automatic acc_t div256(input acc_t s);
    acc_t t;
    t = s;
    if (s[A-1]) t = s + C255;
    return t >>> 8;
  endfunction

  function automatic acc_t clampc(input acc_t v, input acc_t lo, input acc_t hi);
    acc_t o;
    o = v;
    if (v < lo) o = lo;
    if (v > hi) o = hi;
    return o;
  endfunction

  function automatic acc_t expand(input acc_t v, input acc_t m);
    acc_t e;
    e = ((v - L16) * m) >>> 8;
    if (e > CMAX) e = CMAX;
    return e;
  endfunction

  function automatic logic [1:0] tval(input logic lp, input logic pp);
    logic [1:0] t;
    case ({lp, pp})
      2'b00:   t = 2'd0;
      2'b01:   t = 2'd2;
      2'b10:   t = 2'd3;
      default: t = 2'd1;
    endcase
    return t;
  endfunction

  function automatic logic [OUT_BITS-1:0] quant(
    input logic [W-1:0] v,
    input logic [1:0]   t
  );
    logic [W:0] s;
    s = {1'b0, v};
    if (DO_DITH) s = s + ((W+1)'(t) << DSH);
    if (s[W]) s = {1'b0, MAXV};
    return s[W-1 -: OUT_BITS];
  endfunction

  logic                hs_p_q, vs_p_q, lp_q, pp_q;
  logic [W-1:0]        r1_q, g1_q, b1_q;
  ctl_t                ctl1_q, ctl2_q, ctl3_q;
  acc_t                ar_q, ag_q, ab_q;
  logic [W-1:0]        v3r_q, v3g_q, v3b_q;
  logic [OUT_BITS-1:0] vr_q, vg_q, vb_q;
  logic                vhs_q, vvs_q;

  logic                hs_fall, vs_fall, lp_d, pp_d;
  logic [W-1:0]        r1_d, g1_d, b1_d;
  ctl_t                ctl1_d;
  acc_t                rs, gs, bs;
  acc_t                ar_d, ag_d, ab_d;
  acc_t                y3, pb3, pr3;
  logic [W-1:0]        v3r_d, v3g_d, v3b_d;
  logic [1:0]          t4;
  logic [OUT_BITS-1:0] vr_d, vg_d, vb_d;
  logic                vhs_d, vvs_d;

  // S1: line/pixel parity, attenuation, mode capture.
  // The pixel captured on an HSync fall already belongs to the new line.
  always_comb begin
    hs_fall = hs_p_q & ~vid.HSync;
    vs_fall = vs_p_q & ~vid.VSync;
    lp_d    = vs_fall ? 1'b0 : (hs_fall ? ~lp_q : lp_q);
    pp_d    = hs_fall ? 1'b0 : ~pp_q;
    r1_d    = atten(vid.R, vid.scanlines, lp_d);
    g1_d    = atten(vid.G, vid.scanlines, lp_d);
    b1_d    = atten(vid.B, vid.scanlines, lp_d);
    ctl1_d  = '{hs: vid.HSync, vs: vid.VSync, lp: lp_d, pp: pp_d,
                cs: vid.csync_en, yp: vid.ypbpr, yf: vid.ypbpr_full};
  end

  // S2: matrix products; RGB rides through the same registers.
  always_comb begin
    rs = A'(r1_q);
    gs = A'(g1_q);
    bs = A'(b1_q);
    ar_d = rs;
    ag_d = gs;
    ab_d = bs;
    if (ctl1_q.yp) begin
      ar_d = C112 * rs - C94 * gs - C18 * bs;
      ag_d = C66 * rs + C129 * gs + C25 * bs;
      ab_d = C112 * bs - C38 * rs - C74 * gs;
    end
  end

  // S3: scale, offset, clamp, optional full-range expansion.
  always_comb begin
    y3  = clampc(L16 + div256(ag_q), L16, L235);
    pb3 = clampc(L128 + div256(ab_q), L16, L240);
    pr3 = clampc(L128 + div256(ar_q), L16, L240);
    if (ctl2_q.yf) begin
      y3  = expand(y3, C298);
      pb3 = expand(pb3, C291);
      pr3 = expand(pr3, C291);
    end
    v3r_d = W'(ar_q);
    v3g_d = W'(ag_q);
    v3b_d = W'(ab_q);
    if (ctl2_q.yp) begin
      v3r_d = W'(pr3);
      v3g_d = W'(y3);
      v3b_d = W'(pb3);
    end
  end

  // S4: dither, quantise, sync encode.
  always_comb begin
    t4    = tval(ctl3_q.lp, ctl3_q.pp);
    vr_d  = quant(v3r_q, t4);
    vg_d  = quant(v3g_q, t4);
    vb_d  = quant(v3b_q, t4);
    vhs_d = ~ctl3_q.hs;
    vvs_d = ~ctl3_q.vs;
    if (ctl3_q.cs | ctl3_q.yp) begin
      vhs_d = ~(ctl3_q.hs ^ ctl3_q.vs);
      vvs_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hs_p_q <= 1'b0;
      vs_p_q <= 1'b0;
      lp_q   <= 1'b0;
      pp_q   <= 1'b0;
      r1_q   <= '0;
      g1_q   <= '0;
      b1_q   <= '0;
      ctl1_q <= '0;
      ar_q   <= '0;
      ag_q   <= '0;
      ab_q   <= '0;
      ctl2_q <= '0;
      v3r_q  <= '0;
      v3g_q  <= '0;
      v3b_q  <= '0;
      ctl3_q <= '0;
      vr_q   <= '0;
      vg_q   <= '0;
      vb_q   <= '0;
      vhs_q  <= 1'b1;
      vvs_q  <= 1'b1;
    end else if (vid.ce_pix) begin
      hs_p_q <= vid.HSync;
      vs_p_q <= vid.VSync;
      lp_q   <= lp_d;
      pp_q   <= pp_d;
      r1_q   <= r1_d;
      g1_q   <= g1_d;
      b1_q   <= b1_d;
      ctl1_q <= ctl1_d;
      ar_q   <= ar_d;
      ag_q   <= ag_d;
      ab_q   <= ab_d;
      ctl2_q <= ctl1_q;
      v3r_q  <= v3r_d;
      v3g_q  <= v3g_d;
      v3b_q  <= v3b_d;
      ctl3_q <= ctl2_q;
      vr_q   <= vr_d;
      vg_q   <= vg_d;
      vb_q   <= vb_d;
      vhs_q  <= vhs_d;
      vvs_q  <= vvs_d;
    end
  end

  assign vid.VGA_R  = vr_q;
  assign vid.VGA_G  = vg_q;
  assign vid.VGA_B  = vb_q;
  assign vid.VGA_HS = vhs_q;
  assign vid.VGA_VS = vvs_q;

endmodule
